ext_in_port: RTL and testbench
==============================

# ext_in_port

Input-port receiver for the SimpleCPU `IN` instruction (opcode `4'h7`). It is the counterpart of the `OUT` external-output controller. The block accepts bytes from an external producer over a valid/ready handshake and buffers them in a small FIFO. It delivers the head byte to the write-back path when `IN` executes, and stalls the PC while `IN` executes against an empty buffer.

## Interface
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `AW`, 2, pointer width, log2(DEPTH).
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  reset: asynchronous, active-high.
- `ext_data`  in  8  byte from external producer.
- `ext_valid`  in  1  producer has a byte on `ext_data`.
- `ext_ready`  out  1  FIFO can accept a byte this cycle.
- `op`  in  4  opcode (`ins[7:4]`) of the instruction currently executing.
- `in_data`  out  8  byte handed to write-back as the `IN` result.
- `stall`  out  1  `IN` is blocked on an empty FIFO; CPU gates `pc_en` low and holds the instruction.
- `level`  out  AW+1  current FIFO occupancy, 0..DEPTH.
- `rd_total`  out  8  count of bytes consumed by `IN`, wrapping.

## Operation
- Storage: DEPTH×8 array, write pointer `wp`, read pointer `rp` (AW bits, wrap modulo DEPTH), occupancy `level` (AW+1 bits).
- `ext_ready = (level != DEPTH)` is combinational from registered state only. It does not depend on `ext_valid` or `op`.
- Push when `ext_valid && ext_ready` at posedge:
  - `mem[wp] <= ext_data`
  - `wp <= wp+1`
- `in_rd = (op == 4'h7) && (level != 0)`.
- Pop when `in_rd` at posedge:
  - `rp <= rp+1`
  - `rd_total <= rd_total+1`, wrapping `8'hFF`→`8'h00`.
- `in_data = (level != 0) ? mem[rp] : 8'h00`. This is a combinational head-of-queue read and is valid in the same cycle `IN` executes.
- `stall = (op == 4'h7) && (level == 0)`, combinational.
- `level` update per cycle:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on both or neither.
- Boundary rules:
  - Full (`level == DEPTH`): `ext_ready = 0` even if a pop occurs the same cycle. There is no pass-through push-on-full. The producer must hold `ext_valid`/`ext_data` until accepted.
  - Empty with push and `IN` in the same cycle: `stall = 1`, no pop, no bypass. The byte is written. Next cycle `level = 1`, `stall = 0`, and the pop occurs.
  - Push and pop in the same cycle with 0 < level < DEPTH: both occur and `level` is unchanged.
  - Pointer wrap: `rp`/`wp` roll from DEPTH−1 to 0 with no loss.
  - Non-`IN` opcodes never pop and never stall.
- Reset (any time, including mid-handshake):
  - `wp = rp = 0`, `level = 0`, `rd_total = 0`.
  - Buffered bytes are discarded; array contents are not cleared and are don't-care.
  - Outputs while `rst = 1`: `ext_ready = 1`, `in_data = 8'h00`, `level = 0`, `rd_total = 0`, `stall = (op == 4'h7)`.
  - A push presented during reset is not accepted.

## Timing
- Producer-to-visible latency is 1 cycle. A byte accepted at posedge N is on `in_data` and counted in `level` after posedge N.
- `IN` read latency is 0 cycles. `in_data` is sampled by write-back in the `IN` cycle, and the pop commits at the end of that cycle.
- Stall release is 1 cycle after the accepting edge. `stall` drops in the cycle after the push edge that makes `level` nonzero.
- Back-to-back `IN` drains one byte per cycle.
- Sustained throughput is one push and one pop per cycle.
- No combinational path from `ext_valid` to `ext_ready`.

## Test plan
- **Reset and basic transfer.** Assert `rst`, then release it. Push `8'hA5`, then `IN` next cycle.
  - Expect `ext_ready = 1`, `level = 0` during reset.
  - After the push edge: `level = 1`, `in_data = 8'hA5`.
  - After the `IN` edge: `level = 0`, `rd_total = 1`.
- **Fill to full.** Push `8'h01..8'h05` with `ext_valid` held every cycle and no `IN`.
  - Expect 4 accepted, then `ext_ready = 0`, `level = 4`.
  - `8'h05` is held and accepted only after the first `IN`.
  - Four `IN`s return `01, 02, 03, 04`, then `05`.
- **Stall on empty.** Execute `IN` with `level = 0` for 3 cycles, then push `8'h3C`.
  - Expect `stall = 1` for all 3 cycles and the push cycle.
  - Next cycle: `stall = 0`, `in_data = 8'h3C`, then `level = 0`.
- **Simultaneous push and pop at `level = 2`.** Push `8'h77` while executing `IN`.
  - Expect the head popped, `level` stays 2, and FIFO order preserved.
- **Wrap-around.** Run 10 push/`IN` pairs with data `8'h10..8'h19`.
  - Expect in-order output across pointer wrap and `rd_total = 10`.
  - Preload `rd_total` to 255 by traffic; the next pop wraps it to 0.
- **Reset mid-operation.** With `level = 3` and `ext_valid = 1`, pulse `rst` asynchronously between edges.
  - Expect `level = 0`, `rd_total = 0`, `ext_ready = 1` immediately.
  - A following `IN` asserts `stall`.

Source files
------------

// File: rtl/ext_in_port.sv
// Input-port receiver for the SimpleCPU IN instruction: a small byte FIFO fed by an
// external valid/ready producer and drained by IN, with a PC stall when IN finds it empty.
module ext_in_port #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    ext_data,
  input  logic          ext_valid,
  output logic          ext_ready,
  input  logic [3:0]    op,
  output logic [7:0]    in_data,
  output logic          stall,
  output logic [AW:0]   level,
  output logic [7:0]    rd_total
);

  localparam logic [3:0]  OP_IN = 4'h7;
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE   = (AW+1)'(1);

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [AW:0]   r_level;
  logic [7:0]    r_rd_total;

  logic w_is_in;
  logic w_empty;
  logic w_push;
  logic w_pop;

  // Ready depends on registered occupancy only, so a full FIFO refuses even when IN pops.
  assign w_is_in   = (op == OP_IN);
  assign w_empty   = (r_level == '0);
  assign ext_ready = (r_level != FULL);
  assign w_push    = ext_valid && ext_ready;
  assign w_pop     = w_is_in && !w_empty;

  assign in_data  = w_empty ? 8'h00 : r_mem[r_rp];
  assign stall    = w_is_in && w_empty;
  assign level    = r_level;
  assign rd_total = r_rd_total;

  // NOTE: the storage array has no reset; stale bytes are unreachable once level is cleared.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_mem[r_wp] <= ext_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp       <= '0;
      r_rp       <= '0;
      r_level    <= '0;
      r_rd_total <= 8'h00;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp       <= r_rp + 1'b1;
        r_rd_total <= r_rd_total + 8'h01;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + ONE;
        2'b01:   r_level <= r_level - ONE;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: tb/tb_ext_in_port.sv
// Directed self-checking bench for ext_in_port: reset, transfer, full, stall, overlap,
// pointer/counter wrap and asynchronous reset mid-traffic.
module tb_ext_in_port;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ext_data;
  logic       ext_valid;
  logic       ext_ready;
  logic [3:0] op;
  logic [7:0] in_data;
  logic       stall;
  logic [2:0] level;
  logic [7:0] rd_total;

  int errors = 0;
  int checks = 0;

  ext_in_port #(.DEPTH(4), .AW(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ext_data  (ext_data),
    .ext_valid (ext_valid),
    .ext_ready (ext_ready),
    .op        (op),
    .in_data   (in_data),
    .stall     (stall),
    .level     (level),
    .rd_total  (rd_total)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled a few ns after each rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst = 1'b1; ext_valid = 1'b1; ext_data = 8'hEE; op = 4'h7;
    #1;
    checks++; if (ext_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", ext_ready); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", level); end
    checks++; if (in_data !== 8'h00) begin errors++; $display("FAIL rst_in_data: got %h want 00", in_data); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_stall: got %b want 1", stall); end
    tick(); tick();
    checks++; if (level !== 3'd0 || rd_total !== 8'h00) begin errors++; $display("FAIL rst_push_ignored: level=%0d rd_total=%h want 0/00", level, rd_total); end
    ext_valid = 1'b0; op = 4'h0;
    #1 rst = 1'b0;
    tick();
    checks++; if (level !== 3'd0 || stall !== 1'b0) begin errors++; $display("FAIL post_rst: level=%0d stall=%b want 0/0", level, stall); end
  endtask

  task automatic test_basic();
    ext_valid = 1'b1; ext_data = 8'hA5; op = 4'h0;
    tick();
    ext_valid = 1'b0;
    #1;
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL basic_level: got %0d want 1", level); end
    checks++; if (in_data !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h want a5", in_data); end
    op = 4'h7;
    #1;
    checks++; if (stall !== 1'b0 || in_data !== 8'hA5) begin errors++; $display("FAIL basic_in: stall=%b data=%h want 0/a5", stall, in_data); end
    tick();
    op = 4'h0;
    #1;
    checks++; if (level !== 3'd0 || rd_total !== 8'd1) begin errors++; $display("FAIL basic_pop: level=%0d rd_total=%0d want 0/1", level, rd_total); end
  endtask

  task automatic test_fill();
    ext_valid = 1'b1; op = 4'h0;
    for (int i = 1; i <= 4; i++) begin
      ext_data = 8'(i);
      #1;
      checks++; if (ext_ready !== 1'b1) begin errors++; $display("FAIL fill_ready_%0d: got %b want 1", i, ext_ready); end
      tick();
    end
    ext_data = 8'h05;
    #1;
    checks++; if (ext_ready !== 1'b0 || level !== 3'd4) begin errors++; $display("FAIL fill_full: ready=%b level=%0d want 0/4", ext_ready, level); end
    op = 4'h7;
    #1;
    checks++; if (ext_ready !== 1'b0 || in_data !== 8'h01) begin errors++; $display("FAIL fill_full_pop: ready=%b data=%h want 0/01", ext_ready, in_data); end
    tick();
    checks++; if (level !== 3'd3 || ext_ready !== 1'b1) begin errors++; $display("FAIL fill_after_pop: level=%0d ready=%b want 3/1", level, ext_ready); end
    for (int e = 2; e <= 5; e++) begin
      #1;
      checks++; if (in_data !== 8'(e)) begin errors++; $display("FAIL fill_order_%0d: got %h want %h", e, in_data, 8'(e)); end
      tick();
      ext_valid = 1'b0;
    end
    op = 4'h0;
    #1;
    checks++; if (level !== 3'd0 || rd_total !== 8'd6) begin errors++; $display("FAIL fill_drained: level=%0d rd_total=%0d want 0/6", level, rd_total); end
  endtask

  task automatic test_stall_on_empty();
    ext_valid = 1'b0; op = 4'h7;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_cycle_%0d: got %b want 1", c, stall); end
      tick();
    end
    ext_valid = 1'b1; ext_data = 8'h3C;
    #1;
    checks++; if (stall !== 1'b1 || rd_total !== 8'd6) begin errors++; $display("FAIL stall_push_cycle: stall=%b rd_total=%0d want 1/6", stall, rd_total); end
    tick();
    ext_valid = 1'b0;
    #1;
    checks++; if (stall !== 1'b0 || in_data !== 8'h3C || level !== 3'd1) begin errors++; $display("FAIL stall_release: stall=%b data=%h level=%0d want 0/3c/1", stall, in_data, level); end
    tick();
    op = 4'h0;
    #1;
    checks++; if (level !== 3'd0 || rd_total !== 8'd7) begin errors++; $display("FAIL stall_pop: level=%0d rd_total=%0d want 0/7", level, rd_total); end
  endtask

  task automatic test_back_to_back();
    ext_valid = 1'b1; op = 4'h0;
    ext_data = 8'h11; tick();
    ext_data = 8'h22; tick();
    ext_data = 8'h77; op = 4'h7;
    #1;
    checks++; if (in_data !== 8'h11 || level !== 3'd2) begin errors++; $display("FAIL simul_head: data=%h level=%0d want 11/2", in_data, level); end
    tick();
    ext_valid = 1'b0;
    #1;
    checks++; if (level !== 3'd2 || in_data !== 8'h22) begin errors++; $display("FAIL simul_level: level=%0d data=%h want 2/22", level, in_data); end
    tick();
    #1;
    checks++; if (in_data !== 8'h77) begin errors++; $display("FAIL simul_order: got %h want 77", in_data); end
    tick();
    op = 4'h0;
    #1;
    checks++; if (level !== 3'd0 || rd_total !== 8'd10) begin errors++; $display("FAIL simul_drain: level=%0d rd_total=%0d want 0/10", level, rd_total); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 10; i++) begin
      ext_valid = 1'b1; ext_data = 8'h10 + 8'(i); op = 4'h0;
      tick();
      ext_valid = 1'b0; op = 4'h7;
      #1;
      checks++; if (in_data !== 8'h10 + 8'(i)) begin errors++; $display("FAIL wrap_data_%0d: got %h want %h", i, in_data, 8'h10 + 8'(i)); end
      tick();
    end
    op = 4'h0;
    #1;
    checks++; if (rd_total !== 8'd20 || level !== 3'd0) begin errors++; $display("FAIL wrap_total: rd_total=%0d level=%0d want 20/0", rd_total, level); end
    // Sustained one-push-one-pop traffic to bring the counter to 255.
    ext_valid = 1'b1; ext_data = 8'h00; tick();
    op = 4'h7;
    for (int i = 0; i < 234; i++) begin
      ext_data = 8'(i + 1);
      tick();
    end
    ext_valid = 1'b0;
    tick();
    op = 4'h0;
    #1;
    checks++; if (rd_total !== 8'd255 || level !== 3'd0) begin errors++; $display("FAIL total_255: rd_total=%0d level=%0d want 255/0", rd_total, level); end
    ext_valid = 1'b1; ext_data = 8'h5A; tick();
    ext_valid = 1'b0; op = 4'h7; tick();
    op = 4'h0;
    #1;
    checks++; if (rd_total !== 8'd0) begin errors++; $display("FAIL total_wrap: got %0d want 0", rd_total); end
  endtask

  task automatic test_reset_mid();
    ext_valid = 1'b1; op = 4'h0;
    ext_data = 8'hA1; tick();
    ext_data = 8'hA2; tick();
    ext_data = 8'hA3; tick();
    ext_data = 8'hDD;
    #1;
    checks++; if (level !== 3'd3) begin errors++; $display("FAIL mid_preload: got %0d want 3", level); end
    rst = 1'b1;
    #1;
    checks++; if (level !== 3'd0 || rd_total !== 8'd0 || ext_ready !== 1'b1 || in_data !== 8'h00) begin
      errors++; $display("FAIL mid_rst: level=%0d rd_total=%0d ready=%b data=%h want 0/0/1/00", level, rd_total, ext_ready, in_data);
    end
    ext_valid = 1'b0;
    #1 rst = 1'b0;
    op = 4'h7;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mid_stall: got %b want 1", stall); end
    tick();
    checks++; if (stall !== 1'b1 || level !== 3'd0) begin errors++; $display("FAIL mid_stall_hold: stall=%b level=%0d want 1/0", stall, level); end
    op = 4'h0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fill();
    test_stall_on_empty();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
